// File: rtl/outlier_pkg.sv
// Shared definitions for the outlier event logger: channel count, the bit
// layout of a stored event entry, and the hold-off state encoding.
package outlier_pkg;

    localparam int N_CH = 4;

    // Stored entry layout: {ts[TS_W-1:0], new[3:0], level[3:0]}
    // The timestamp sits at [TS_W+7:8], the flags payload below it.
    localparam int LEVEL_LSB = 0;
    localparam int NEW_LSB   = 4;
    localparam int TS_LSB    = 8;

    // Flags payload of an entry; the timestamp is prepended by the top
    // because its width is a parameter of the instance.
    typedef struct packed {
        logic [N_CH-1:0] new_ch;
        logic [N_CH-1:0] level;
    } event_t;

    // Hold-off FSM states: IDLE whenever the hold-off counter is zero.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

endpackage

// File: rtl/outlier_event_logger_fifo.sv
// Show-ahead synchronous FIFO with a registered occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_u #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/outlier_event_logger.sv
// Turns rising edges of the outlier flag vector into timestamped events,
// merges edges that arrive within the hold-off window, and queues the
// events for a valid/ready consumer. Drops on a full queue are counted.
module outlier_event_logger
    import outlier_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TS_W    = 24,
    parameter int HOLDOFF = 8,
    parameter int OVF_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          outlier_flags,
    input  logic                     clear_ovf,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [N_CH-1:0]          evt_new,
    output logic [N_CH-1:0]          evt_level,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [OVF_W-1:0]         ovf_count
);

    localparam int ENTRY_W = TS_W + TS_LSB;
    localparam int HO_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [N_CH-1:0]    flags_d;
    logic [N_CH-1:0]    rise;
    logic [TS_W-1:0]    ts;
    logic [HO_W-1:0]    holdoff_cnt;
    logic [HO_W-1:0]    holdoff_nxt;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    pending_nxt;
    hold_state_e        state;
    logic               push;
    logic [N_CH-1:0]    push_new;
    logic               pop;
    logic               drop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
    event_t             push_evt;
    event_t             head_evt;

    assign rise  = outlier_flags & ~flags_d;
    assign state = (holdoff_cnt == '0) ? ST_IDLE : ST_HOLD;

    // Free-running timestamp and previous-cycle flags for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts      <= '0;
            flags_d <= '0;
        end else begin
            ts      <= ts + TS_W'(1);
            flags_d <= outlier_flags;
        end
    end

    // Hold-off state register: remaining hold cycles and merged edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff_cnt <= '0;
            pending     <= '0;
        end else begin
            holdoff_cnt <= holdoff_nxt;
            pending     <= pending_nxt;
        end
    end

    // Hold-off next state: push fresh edges when idle, merge them while
    // holding, and flush the merged set on the last hold cycle.
    always_comb begin
        holdoff_nxt = holdoff_cnt;
        pending_nxt = pending;
        push        = 1'b0;
        push_new    = '0;
        case (state)
            ST_IDLE: begin
                if (rise != '0) begin
                    push     = 1'b1;
                    push_new = rise;
                    if (HOLDOFF != 0) begin
                        holdoff_nxt = HO_W'(HOLDOFF);
                    end
                end
            end
            ST_HOLD: begin
                if (holdoff_cnt == HO_W'(1)) begin
                    pending_nxt = '0;
                    if ((pending | rise) != '0) begin
                        push        = 1'b1;
                        push_new    = pending | rise;
                        holdoff_nxt = HO_W'(HOLDOFF);
                    end else begin
                        holdoff_nxt = '0;
                    end
                end else begin
                    pending_nxt = pending | rise;
                    holdoff_nxt = holdoff_cnt - HO_W'(1);
                end
            end
            default: begin
                holdoff_nxt = '0;
            end
        endcase
    end

    assign push_evt.new_ch = push_new;
    assign push_evt.level  = outlier_flags;
    assign wdata           = {ts, push_evt};

    assign pop  = evt_valid & evt_ready;
    assign drop = push & fifo_full & ~pop;

    sync_fifo_u #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_level)
    );

    // Head fields are forced to zero while empty so reset shows all zeros.
    assign head_evt  = event_t'(rdata[TS_LSB-1:0]);
    assign evt_valid = ~fifo_empty;
    assign evt_ts    = evt_valid ? rdata[TS_LSB +: TS_W] : '0;
    assign evt_new   = evt_valid ? head_evt.new_ch : '0;
    assign evt_level = evt_valid ? head_evt.level : '0;

    // Saturating drop counter; a clear coinciding with a drop leaves one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clear_ovf) begin
            ovf_count <= drop ? OVF_W'(1) : '0;
        end else if (drop && (ovf_count != '1)) begin
            ovf_count <= ovf_count + OVF_W'(1);
        end
    end

endmodule

// File: tb/tb_outlier_event_logger.sv
// Self-checking bench for outlier_event_logger: directed scenarios plus
// random traffic compared against a cycle-indexed reference model.
module tb_outlier_event_logger;

    localparam int DEPTH   = 16;
    localparam int TS_W    = 8;
    localparam int HOLDOFF = 8;
    localparam int OVF_W   = 4;
    localparam int OVF_MAX = (1 << OVF_W) - 1;
    localparam int TS_MOD  = 1 << TS_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [3:0]             outlier_flags = '0;
    logic                   clear_ovf = 1'b0;
    logic                   evt_valid;
    logic                   evt_ready = 1'b0;
    logic [TS_W-1:0]        evt_ts;
    logic [3:0]             evt_new;
    logic [3:0]             evt_level;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [OVF_W-1:0]       ovf_count;

    typedef struct {
        int         ts;
        logic [3:0] nw;
        logic [3:0] lv;
    } entry_t;

    entry_t     model_q[$];
    int         cyc;
    int         last_push;
    int         ovf_m;
    logic [3:0] prev_flags;
    logic [3:0] pend;
    int         n_cmp = 0;
    int         n_bad = 0;

    outlier_event_logger #(
        .DEPTH   (DEPTH),
        .TS_W    (TS_W),
        .HOLDOFF (HOLDOFF),
        .OVF_W   (OVF_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .outlier_flags (outlier_flags),
        .clear_ovf     (clear_ovf),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_ts        (evt_ts),
        .evt_new       (evt_new),
        .evt_level     (evt_level),
        .fifo_level    (fifo_level),
        .ovf_count     (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        cyc        = 0;
        last_push  = -1000;
        ovf_m      = 0;
        prev_flags = '0;
        pend       = '0;
    endtask

    // Reference behaviour for the clock edge about to happen, expressed in
    // absolute cycle numbers: a hold window covers the HOLDOFF cycles after
    // the most recent push, and its last cycle flushes merged edges.
    task automatic modelStep(input logic [3:0] f, input logic r, input logic clr);
        logic [3:0] rise;
        logic       push;
        logic       drop;
        logic [3:0] nw;
        rise = f & ~prev_flags;
        prev_flags = f;
        push = 1'b0;
        drop = 1'b0;
        nw = '0;
        if (HOLDOFF == 0 || cyc > last_push + HOLDOFF) begin
            if (rise != 0) begin
                push = 1'b1;
                nw = rise;
            end
        end else begin
            pend = pend | rise;
            if (cyc == last_push + HOLDOFF) begin
                if (pend != 0) begin
                    push = 1'b1;
                    nw = pend;
                end
                pend = '0;
            end
        end
        if (push) last_push = cyc;
        if (r && model_q.size() > 0) void'(model_q.pop_front());
        if (push) begin
            if (model_q.size() < DEPTH) model_q.push_back('{cyc % TS_MOD, nw, f});
            else drop = 1'b1;
        end
        if (clr) ovf_m = drop ? 1 : 0;
        else if (drop && ovf_m < OVF_MAX) ovf_m++;
        cyc++;
    endtask

    task automatic checkState();
        checkOutput("valid", evt_valid, model_q.size() != 0);
        checkOutput("fifo_level", fifo_level, model_q.size());
        checkOutput("ovf_count", ovf_count, ovf_m);
        if (model_q.size() != 0) begin
            checkOutput("head_ts", evt_ts, model_q[0].ts);
            checkOutput("head_new", evt_new, model_q[0].nw);
            checkOutput("head_level", evt_level, model_q[0].lv);
        end
    endtask

    // Drive one cycle of inputs from a falling edge, step the model, and
    // compare at the next falling edge.
    task automatic applyStimulus(input logic [3:0] f, input logic r, input logic clr);
        outlier_flags = f;
        evt_ready     = r;
        clear_ovf     = clr;
        modelStep(f, r, clr);
        @(posedge clk);
        @(negedge clk);
        checkState();
    endtask

    // Asynchronous reset asserted mid-cycle with flags held at f.
    task automatic doReset(input logic [3:0] f);
        outlier_flags = f;
        evt_ready     = 1'b0;
        clear_ovf     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_ovf", ovf_count, 0);
        checkOutput("rst_ts", evt_ts, 0);
        checkOutput("rst_new", evt_new, 0);
        checkOutput("rst_lvl", evt_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [3:0] rf;
        int         ready_pct;
        modelReset();
        @(negedge clk);

        // Single event at ts=10, flag then held high.
        doReset(4'b0000);
        repeat (10) applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_valid", evt_valid, 1);
        checkOutput("single_ts", evt_ts, 10);
        checkOutput("single_new", evt_new, 4'b0100);
        checkOutput("single_lvl", evt_level, 4'b0100);
        repeat (15) applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_once", fifo_level, 0);

        // Hold-off merge: ch0 at 20, ch2 at 23 flushed at 28.
        doReset(4'b0000);
        repeat (20) applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0);
        repeat (18) applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("merge_count", fifo_level, 2);
        checkOutput("merge_ts0", evt_ts, 20);
        checkOutput("merge_new0", evt_new, 4'b0001);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("merge_ts1", evt_ts, 28);
        checkOutput("merge_new1", evt_new, 4'b0100);
        checkOutput("merge_lvl1", evt_level, 4'b0101);
        repeat (3) applyStimulus(4'b0101, 1'b1, 1'b0);

        // Backpressure and overflow with isolated edges.
        doReset(4'b0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            repeat (9) applyStimulus(4'b0000, 1'b0, 1'b0);
        end
        checkOutput("ovf_level16", fifo_level, 16);
        checkOutput("ovf_count4", ovf_count, 4);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            repeat (9) applyStimulus(4'b0000, 1'b0, 1'b0);
        end
        checkOutput("ovf_saturate", ovf_count, OVF_MAX);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        checkOutput("ovf_clear_drop", ovf_count, 1);
        repeat (9) applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("full_pushpop_level", fifo_level, 16);
        checkOutput("full_pushpop_ovf", ovf_count, 1);
        repeat (20) applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("drained", fifo_level, 0);

        // Timestamp wrap: edge at cycle 257 carries ts=1.
        doReset(4'b0000);
        repeat (257) applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("wrap_ts", evt_ts, 1);

        // Random traffic with varying backpressure.
        doReset(4'b0000);
        rf = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) ready_pct = $urandom_range(90, 5);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) rf[b] = ~rf[b];
            end
            applyStimulus(rf, $urandom_range(99) < ready_pct, $urandom_range(63) == 0);
        end

        // Reset mid-operation with queued entries and a pending mask.
        doReset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1000, 1'b0, 1'b0);
            repeat (9) applyStimulus(4'b0000, 1'b0, 1'b0);
        end
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        checkOutput("pre_rst_level", fifo_level, 6);
        doReset(4'b0010);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("post_rst_valid", evt_valid, 1);
        checkOutput("post_rst_ts", evt_ts, 0);
        checkOutput("post_rst_new", evt_new, 4'b0010);
        repeat (HOLDOFF + 3) applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("post_rst_no_merge", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
